// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the MUL/DIV sequencer.
// Imported by the sequencer top and its divide step.
package mul_div_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_DIVU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_e;

    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_ITERS   = 32;

    // 0x80000000 maps to itself, which is the right unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic s, input logic [31:0] v);
        return s ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_32bit.sv
// Combinational 32x32 signed multiplier, radix-2 Booth recoding.
// Produces the full 64-bit two's-complement product.
module mul_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [63:0] aext;
    logic [32:0] bx;
    logic [63:0] acc;

    assign aext = {{32{a[31]}}, a};
    assign bx   = {b, 1'b0};

    always_comb begin
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            unique case (bx[i+1 -: 2])
                2'b01:   acc = acc + (aext << i);
                2'b10:   acc = acc - (aext << i);
                default: acc = acc;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/mul_div_sequencer_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] q,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] q_next
);

    logic [32:0] sh;
    logic [32:0] diff;
    logic        fits;

    assign sh   = {rem, q[31]};
    assign diff = sh - {1'b0, divisor};
    assign fits = (sh >= {1'b0, divisor});

    // rem < divisor on entry, so the difference always fits in 32 bits.
    always_comb begin
        rem_next = sh[31:0];
        q_next   = {q[30:0], 1'b0};
        if (fits) begin
            rem_next = diff[31:0];
            q_next   = {q[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multicycle MUL/DIV/DIVU unit behind a start/done handshake.
// Results land in HI/LO holding registers read by the datapath.
module mul_div_sequencer
    import mul_div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_ITERS - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic        sneg_q, sneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic [63:0] prod;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        is_sdiv;

    // Multiplier sees only the latched operands, stable through MUL_WAIT.
    mul_32bit u_mul (
        .a       (opa_q),
        .b       (opb_q),
        .product (prod)
    );

    div_step u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .divisor  (opb_q),
        .rem_next (rem_nx),
        .q_next   (quo_nx)
    );

    assign is_sdiv = (op == OP_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sneg_d  = sneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (op != OP_RSVD)) begin
                    dbz_d = 1'b0;
                    opa_d = a;
                    opb_d = b;
                    if (op == OP_MUL) begin
                        cnt_d   = MUL_CNT;
                        state_d = S_MUL_WAIT;
                    end else if (b == '0) begin
                        dbz_d   = 1'b1;
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = is_sdiv ? mag32(a) : a;
                        opb_d   = is_sdiv ? mag32(b) : b;
                        sneg_d  = is_sdiv & (a[31] ^ b[31]);
                        rneg_d  = is_sdiv & a[31];
                        rem_d   = '0;
                        cnt_d   = DIV_CNT;
                        state_d = S_DIV_RUN;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    state_d = S_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV_FIX: begin
                lo_d    = neg_if(sneg_q, quo_q);
                hi_d    = neg_if(rneg_q, rem_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sneg_q  <= sneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Multicycle MUL/DIV unit for the CPU datapath. It shares the team's existing combinational 32-bit signed Booth multiplier (mul_32bit) and a sequential restoring divider behind one start/done handshake. Results are written into HI/LO holding registers that the datapath reads.
- MUL is given MUL_LAT cycles for timing closure.
- DIV/DIVU is iterated one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width (only 32 supported; matches mul_32bit).
- MUL_LAT, 2, cycles the registered operands are held on the combinational multiplier before the product is captured (must be >=1).

Ports:
- clock  in  1  system clock
- clear  in  1  reset: synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  00=MUL signed, 01=DIV signed, 10=DIVU unsigned, 11=reserved
- a  in  32  multiplicand / dividend
- b  in  32  multiplier / divisor
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; HI/LO valid this cycle
- hi  out  32  MUL: product[63:32]; DIV: remainder
- lo  out  32  MUL: product[31:0]; DIV: quotient
- div_by_zero  out  1  set by DIV/DIVU with b==0; cleared on the next accepted start

Behaviour:
- Reset (clear=1 at posedge, any state): state=IDLE; hi=lo=0; busy=done=div_by_zero=0. Abandons any in-flight operation.
- Accept rule: start=1 in IDLE with op!=11 latches a, b, op and clears div_by_zero.
  - start while busy (including the DONE cycle) is ignored.
  - op=11 is ignored; the block stays IDLE.
- FSM states: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE.
- IDLE -> MUL_WAIT on accepted MUL:
  - cnt = MUL_LAT-1.
  - Multiplier inputs are driven only from the latched operand registers and stay stable until capture.
- MUL_WAIT: cnt decrements each cycle. When cnt==0, {hi,lo} <= 64-bit signed product, then go to DONE.
- IDLE -> DONE on accepted DIV/DIVU with b==0: div_by_zero=1, hi=a, lo=32'hFFFFFFFF.
- IDLE -> DIV_RUN on DIV/DIVU with b!=0:
  - DIV loads |a| and |b| and records sign_q = a[31]^b[31] and sign_r = a[31].
  - DIVU loads raw values with both signs = 0.
  - rem = 0 (33-bit), cnt = 31.
- DIV_RUN, one restoring step per cycle:
  - rem = {rem[31:0], q[31]}, q <<= 1.
  - If rem >= divisor: rem -= divisor and q[0] = 1.
  - After the cnt==0 step, go to DIV_FIX.
- DIV_FIX:
  - lo = sign_q ? -q : q.
  - hi = sign_r ? -rem[31:0] : rem[31:0].
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. hi/lo hold until the next capture or reset.
- Latency (start accepted at cycle 0):
  - MUL: done at cycle MUL_LAT+1 (3 by default).
  - DIV/DIVU: done at cycle 34.
  - Divide by zero: done at cycle 1.
- Arithmetic rules:
  - The magnitude of 0x80000000 is 0x80000000, treated unsigned in 32 bits.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (wraps, no flag).
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- Back-to-back: the earliest next start is accepted the cycle after DONE.

Decomposition:
- Shared package mul_div_pkg holds:
  - op encodings: OP_MUL, OP_DIV, OP_DIVU, OP_RSVD
  - the state enum/localparams
  - default MUL_LAT
  - the DIV_ITERS=32 constant
- Sub-modules:
  - mul_32bit is instantiated unchanged.
  - One natural new sub-module is div_step: a combinational single restoring iteration with inputs rem, q, divisor and outputs rem_next, q_next.

Test Plan:
1. MUL a=7, b=-3 (0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at cycle 3, busy high cycles 1-3.
2. MUL a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; with a second start at cycle 2 -> ignored, result unchanged.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at cycle 34. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0xFFFFFFFF, b=16 -> lo=0x0FFFFFFF, hi=0x0000000F. DIV of the same operands -> lo=0, hi=0xFFFFFFFF.
5. DIV a=5, b=0 -> div_by_zero=1, hi=5, lo=0xFFFFFFFF, done at cycle 1. The next MUL 2*3 clears the flag, giving hi=0, lo=6.
6. clear asserted at cycle 10 of a DIV -> next cycle IDLE, busy=0, hi=lo=0, no done pulse. op=11 start -> stays IDLE, no done.
